legv8_multicycle_ctrl: RTL
==========================

// Module: legv8_multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the LEGv8 datapath. Sequences fetch/decode/execute/memory/writeback per instruction.
//  Decodes Instr[31:21] and drives every datapath select, including the 2-bit immediate-type select (SignOp) of the sign extender.
//  Handshakes with instruction and data memories (req/ready) and halts on undefined opcodes.
// PARAMETERS
//  CNT_W    32   width of performance counters (PERF_CNT_EN only)
// PORTS
//  CLK          in   1   single clock; all state updates on posedge
//  Reset        in   1   synchronous, active-high reset
//  Opcode       in   11  Instr[31:21] from instruction register
//  Zero         in   1   ALU zero flag, valid in EXEC
//  imem_ready   in   1   instruction memory data valid
//  dmem_ready   in   1   data memory access complete
//  imem_req     out  1   instruction fetch request
//  IRWrite      out  1   load instruction register
//  PCWrite      out  1   update PC (exactly one pulse per retired instruction)
//  PCSrc        out  1   0=PC+4, 1=PC+(SignExt<<2)
//  Reg2Loc      out  1   1 selects Instr[4:0] as read reg 2 (STUR, CBZ/CBNZ)
//  ALUSrc       out  1   1 selects sign-extended immediate
//  ALUOp        out  2   00 add, 01 pass B, 10 R-type funct decode
//  SignOp       out  2   00 B(26b), 01 CB(19b), 10 D(9b), 11 I(12b zero-ext)
//  MemRead      out  1   data memory read request
//  MemWrite     out  1   data memory write request
//  MemtoReg     out  1   1 selects memory data for writeback
//  RegWrite     out  1   register file write enable
//  state        out  3   current FSM state (debug)
//  instr_done   out  1   1-cycle pulse coincident with retiring PCWrite
//  illegal      out  1   sticky: undefined opcode decoded
// BEHAVIOUR
//  Reset (sync, wins over all inputs incl. ready): state=FETCH, all outputs 0, illegal=0; in-flight mem request dropped.
//  Classes: R(ADD 458,SUB 658,AND 450,ORR 550); I(ADDI 488/489,SUBI 688/689); D(LDUR 7C2,STUR 7C0);
//   B(Opcode[10:5]=000101); CB(CBZ Opcode[10:3]=B4, CBNZ B5); anything else = ILLEGAL.
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=7.
//  FETCH: imem_req=1 held until imem_ready; on ready IRWrite=1 same cycle -> DECODE. No timeout.
//  DECODE: class latched from Opcode; 1 cycle; ILLEGAL -> HALT (illegal=1), else -> EXEC.
//  EXEC: R: ALUOp=10 -> WB. I: ALUSrc=1,SignOp=11 -> WB. D: ALUSrc=1,SignOp=10 -> MEM.
//   B: SignOp=00,PCSrc=1,PCWrite=1 -> FETCH. CB: Reg2Loc=1,ALUOp=01,SignOp=01; taken = Zero (CBZ) / !Zero (CBNZ);
//   PCSrc=taken, PCWrite=1 -> FETCH.
//  MEM: MemRead (LDUR) or MemWrite (STUR) held until dmem_ready. LDUR -> WB; STUR: PCWrite=1,PCSrc=0 on ready -> FETCH.
//  WB: RegWrite=1, MemtoReg=1 iff LDUR, PCWrite=1, PCSrc=0 -> FETCH.
//  HALT: all strobes 0, stays until Reset.
//  SignOp/ALUSrc/Reg2Loc/ALUOp held constant from DECODE through retire for the latched class; 00/0 when idle.
//  Zero-wait latency (cycles FETCH..retire): R/I 4, LDUR 5, STUR 4, B/CB 3. Each ready wait adds 1/cycle.
//  Ready asserted outside its wait state is ignored. RegWrite and MemWrite never both 1.
// CONFIGURATION
//  LEGV8_PERF_CNT_EN defined: adds outputs cycle_cnt[CNT_W-1:0] (+1 every non-reset cycle, not in HALT)
//   and instr_cnt[CNT_W-1:0] (+1 per instr_done); both wrap modulo 2^CNT_W; cleared by Reset.
//  Undefined: ports and counter logic absent; all other behaviour identical.
// STRUCTURE
//  Package legv8_ctrl_pkg: state enum, opcode constants, instruction-class enum, SignOp and ALUOp codes.
//  Sub-module legv8_opcode_decoder: combinational Opcode -> class; FSM instantiates it once.
// TESTING
//  Reset mid-MEM of LDUR with dmem_ready=1 same cycle -> next cycle state=0, RegWrite=0, MemRead=0.
//  ADD (Opcode 458), zero-wait -> states 0,1,2,4; RegWrite=1 and PCWrite=1 only in cycle 4, PCSrc=0.
//  LDUR (7C2), dmem_ready after 3 waits -> MemRead high 3+1 cycles, SignOp=10, then WB with MemtoReg=1.
//  CBZ (5A0) Zero=1 -> PCSrc=1,PCWrite=1 in EXEC; CBNZ (5A8) Zero=1 -> PCSrc=0; SignOp=01, Reg2Loc=1.
//  Opcode 000 -> HALT, illegal=1 sticky across 10 cycles of imem_ready=1; PCWrite never asserts.
//  PERF_CNT_EN: 3 B instrs (0A0) zero-wait -> instr_cnt=3, cycle_cnt=9 at third instr_done+1.

Source files
------------

// File: rtl/legv8_ctrl_pkg.sv
// rtl/legv8_ctrl_pkg.sv - shared types, opcode constants and select codes for the LEGv8 multi-cycle control
package legv8_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } ctrl_state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LDUR,
        CLS_STUR,
        CLS_B,
        CLS_CBZ,
        CLS_CBNZ,
        CLS_ILLEGAL
    } instr_class_e;

    // Full 11-bit opcodes
    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;

    // I-format opcodes are 10 bits wide (Opcode[10:1]); bit 0 belongs to the immediate
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;

    // B-format is Opcode[10:5]; CB-format is Opcode[10:3]
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ = 8'hB5;

    // Sign-extender immediate-type select
    localparam logic [1:0]  SIGN_B  = 2'b00;
    localparam logic [1:0]  SIGN_CB = 2'b01;
    localparam logic [1:0]  SIGN_D  = 2'b10;
    localparam logic [1:0]  SIGN_I  = 2'b11;

    // ALU operation select
    localparam logic [1:0]  ALU_ADD    = 2'b00;
    localparam logic [1:0]  ALU_PASS_B = 2'b01;
    localparam logic [1:0]  ALU_RTYPE  = 2'b10;

    typedef struct packed {
        logic       reg2loc;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [1:0] sign_op;
    } dp_sel_t;

    // Datapath selects that stay constant for a whole instruction of the given class
    function automatic dp_sel_t class_selects(input instr_class_e c);
        dp_sel_t s;
        s = '0;
        case (c)
            CLS_R: begin
                s.alu_op  = ALU_RTYPE;
            end
            CLS_I: begin
                s.alu_src = 1'b1;
                s.sign_op = SIGN_I;
            end
            CLS_LDUR: begin
                s.alu_src = 1'b1;
                s.alu_op  = ALU_ADD;
                s.sign_op = SIGN_D;
            end
            CLS_STUR: begin
                s.reg2loc = 1'b1;
                s.alu_src = 1'b1;
                s.alu_op  = ALU_ADD;
                s.sign_op = SIGN_D;
            end
            CLS_B: begin
                s.sign_op = SIGN_B;
            end
            CLS_CBZ, CLS_CBNZ: begin
                s.reg2loc = 1'b1;
                s.alu_op  = ALU_PASS_B;
                s.sign_op = SIGN_CB;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/legv8_opcode_decoder.sv
// rtl/legv8_opcode_decoder.sv - combinational Instr[31:21] to instruction-class decoder
module legv8_opcode_decoder
    import legv8_ctrl_pkg::*;
(
    input  logic [10:0]  opcode,
    output instr_class_e cls
);

    // Formats are distinguished by opcode field width; unmatched patterns are illegal
    always_comb begin
        cls = CLS_ILLEGAL;
        if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) begin
            cls = CLS_R;
        end else if (opcode[10:1] == OP_ADDI || opcode[10:1] == OP_SUBI) begin
            cls = CLS_I;
        end else if (opcode == OP_LDUR) begin
            cls = CLS_LDUR;
        end else if (opcode == OP_STUR) begin
            cls = CLS_STUR;
        end else if (opcode[10:5] == OP_B) begin
            cls = CLS_B;
        end else if (opcode[10:3] == OP_CBZ) begin
            cls = CLS_CBZ;
        end else if (opcode[10:3] == OP_CBNZ) begin
            cls = CLS_CBNZ;
        end
    end

endmodule

// File: rtl/legv8_multicycle_ctrl.sv
// rtl/legv8_multicycle_ctrl.sv - LEGv8 multi-cycle control FSM; LEGV8_PERF_CNT_EN adds cycle/instruction counters
module legv8_multicycle_ctrl
    import legv8_ctrl_pkg::*;
`ifdef LEGV8_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic [10:0]      Opcode,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             Reg2Loc,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic [1:0]       SignOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic             illegal
`ifdef LEGV8_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    ctrl_state_e  state_q;
    instr_class_e dec_cls;
    instr_class_e cls_q;
    instr_class_e sel_cls;
    dp_sel_t      sel;
    logic         sel_active;
    logic         pc_write_q;
    logic         stur_done;

    legv8_opcode_decoder u_decoder (
        .opcode (Opcode),
        .cls    (dec_cls)
    );

    // Sequencer: state, latched class and the strobes that are known one cycle ahead
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= S_FETCH;
            cls_q      <= CLS_ILLEGAL;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            RegWrite   <= 1'b0;
            MemtoReg   <= 1'b0;
            pc_write_q <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            RegWrite   <= 1'b0;
            MemtoReg   <= 1'b0;
            pc_write_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cls_q <= dec_cls;
                    case (dec_cls)
                        CLS_ILLEGAL: begin
                            state_q <= S_HALT;
                            illegal <= 1'b1;
                        end
                        CLS_B, CLS_CBZ, CLS_CBNZ: begin
                            state_q    <= S_EXEC;
                            pc_write_q <= 1'b1;
                        end
                        default: state_q <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (cls_q)
                        CLS_R, CLS_I: begin
                            state_q    <= S_WB;
                            RegWrite   <= 1'b1;
                            pc_write_q <= 1'b1;
                        end
                        CLS_LDUR: begin
                            state_q <= S_MEM;
                            MemRead <= 1'b1;
                        end
                        CLS_STUR: begin
                            state_q  <= S_MEM;
                            MemWrite <= 1'b1;
                        end
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        if (cls_q == CLS_LDUR) begin
                            state_q    <= S_WB;
                            RegWrite   <= 1'b1;
                            MemtoReg   <= 1'b1;
                            pc_write_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Class selects: taken straight from the decoder in DECODE, from the latched class afterwards
    always_comb begin
        sel_cls    = (state_q == S_DECODE) ? dec_cls : cls_q;
        sel_active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)    || (state_q == S_WB);
        sel        = sel_active ? class_selects(sel_cls) : '0;
    end

    // Branch target select is only meaningful in EXEC, where Zero is valid
    always_comb begin
        PCSrc = 1'b0;
        if (state_q == S_EXEC) begin
            case (cls_q)
                CLS_B:    PCSrc = 1'b1;
                CLS_CBZ:  PCSrc = Zero;
                CLS_CBNZ: PCSrc = !Zero;
                default:  PCSrc = 1'b0;
            endcase
        end
    end

    // Ready-qualified strobes react in the same cycle; Reset suppresses them so a late ready is dropped
    assign imem_req   = (state_q == S_FETCH) && !Reset;
    assign IRWrite    = imem_req && imem_ready;
    assign stur_done  = (state_q == S_MEM) && (cls_q == CLS_STUR) && dmem_ready && !Reset;
    assign PCWrite    = pc_write_q || stur_done;
    assign instr_done = PCWrite;

    assign Reg2Loc    = sel.reg2loc;
    assign ALUSrc     = sel.alu_src;
    assign ALUOp      = sel.alu_op;
    assign SignOp     = sel.sign_op;
    assign state      = state_q;

`ifdef LEGV8_PERF_CNT_EN
    // Free-running counters; they stop counting cycles once halted and wrap naturally
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (instr_done) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
